block_memory_atomic: RTL

- Next-generation bus-attached memory core: one WIDTH x DEPTH memory on the 16-bit daisy-chained register bus, plus a user port on the same clock.
- Adds over the previous core:
  - single clock domain with asynchronous reset;
  - atomic (tear-free) wide-word writes and reads from the bus;
  - a direction MODE;
  - a corrected address range.
- Sits in the bus chain between other cores: transactions enter on *_i and leave on *_o.

---
 rtl/block_memory_atomic.sv | 111 +++++++++++
 1 files changed

// File: rtl/block_memory_atomic.sv
// Bus-attached WIDTH x DEPTH memory with tear-free multi-chunk bus access
// and a same-clock user port; bus traffic is forwarded with 2-cycle latency.
module block_memory_atomic #(
   parameter int unsigned BASE_ADDR = 0,
   parameter int unsigned WIDTH     = 16,
   parameter int unsigned DEPTH     = 256,
   parameter int unsigned MODE      = 0,
   localparam int unsigned N_CHUNKS   = (WIDTH + 15) / 16,
   localparam int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [15:0]           addr_i,
   input  logic [15:0]           data_i,
   input  logic                  rw_i,
   input  logic                  valid_i,
   output logic [15:0]           addr_o,
   output logic [15:0]           data_o,
   output logic                  rw_o,
   output logic                  valid_o,
   input  logic [ADDR_WIDTH-1:0] user_addr,
   input  logic [WIDTH-1:0]      user_din,
   output logic [WIDTH-1:0]      user_dout,
   input  logic                  user_we
);

   localparam int unsigned SPAN = DEPTH * N_CHUNKS;
   localparam int unsigned PW   = N_CHUNKS * 16;
   localparam int unsigned CW   = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
   localparam logic [CW-1:0] LAST_CHUNK = CW'(N_CHUNKS - 1);

   logic [WIDTH-1:0]      mem [DEPTH];
   logic [16:0]           off_ext;
   logic [15:0]           off;
   logic                  in_range;
   logic                  bus_wr;
   logic                  bus_rd;
   logic                  commit;
   logic                  user_wr;
   logic [ADDR_WIDTH-1:0] word;
   logic [CW-1:0]         chunk;
   logic [PW-1:0]         shadow;
   logic [PW-1:0]         snap;
   logic [PW-1:0]         commit_vec;

   logic [15:0]           s1_addr;
   logic [15:0]           s1_data;
   logic                  s1_rw;
   logic                  s1_valid;
   logic                  s1_rd;
   logic [CW-1:0]         s1_chunk;

   // Borrow bit of the 17-bit subtraction flags addresses below BASE_ADDR.
   always_comb begin
      off_ext    = {1'b0, addr_i} - 17'(BASE_ADDR);
      off        = off_ext[15:0];
      in_range   = valid_i && !off_ext[16] && (32'(off) < SPAN);
      word       = ADDR_WIDTH'(off / 16'(N_CHUNKS));
      chunk      = CW'(off % 16'(N_CHUNKS));
      bus_wr     = in_range && rw_i && (MODE != 1);
      bus_rd     = in_range && !rw_i && (MODE != 2);
      commit     = bus_wr && (chunk == LAST_CHUNK);
      user_wr    = user_we && (MODE != 2);
      commit_vec = shadow;
      commit_vec[PW-16 +: 16] = data_i;
   end

   // User write is issued last so it wins a same-word collision with a commit.
   always_ff @(posedge clk) begin
      if (commit && !(user_wr && (user_addr == word)))
         mem[word] <= WIDTH'(commit_vec);
      if (user_wr)
         mem[user_addr] <= user_din;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_addr   <= '0;
         s1_data   <= '0;
         s1_rw     <= 1'b0;
         s1_valid  <= 1'b0;
         s1_rd     <= 1'b0;
         s1_chunk  <= '0;
         shadow    <= '0;
         snap      <= '0;
         addr_o    <= '0;
         data_o    <= '0;
         rw_o      <= 1'b0;
         valid_o   <= 1'b0;
         user_dout <= '0;
      end else begin
         s1_addr  <= addr_i;
         s1_data  <= data_i;
         s1_rw    <= rw_i;
         s1_valid <= valid_i;
         s1_rd    <= bus_rd;
         s1_chunk <= chunk;
         if (bus_wr && !commit)
            shadow[int'(chunk)*16 +: 16] <= data_i;
         // Snapshot is read-first: a commit in the same cycle is not seen.
         if (bus_rd && (chunk == '0))
            snap <= PW'(mem[word]);
         addr_o  <= s1_addr;
         data_o  <= s1_rd ? snap[int'(s1_chunk)*16 +: 16] : s1_data;
         rw_o    <= s1_rw;
         valid_o <= s1_valid;
         user_dout <= mem[user_addr];
      end
   end

endmodule
